// File: rtl/boot_fetch_ctrl.sv
// Boot sequencer and instruction-SRAM arbiter for the uDLX fetch stage.
// Holds the core in boot mode, streams a loader image into SRAM, then releases the core.
module boot_fetch_ctrl #(
  parameter int                       PC_DATA_WIDTH     = 20,
  parameter int                       INSTRUCTION_WIDTH = 32,
  parameter logic [PC_DATA_WIDTH-1:0] BOOT_BASE_ADDRESS = 20'h0,
  parameter int                       COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         boot_start_in,
  input  logic [COUNT_WIDTH-1:0]       boot_length_in,
  input  logic [INSTRUCTION_WIDTH-1:0] boot_data_in,
  input  logic                         boot_valid_in,
  output logic                         boot_ready_out,
  input  logic [PC_DATA_WIDTH-1:0]     fetch_addr_in,
  output logic [PC_DATA_WIDTH-1:0]     inst_mem_addr_out,
  output logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_out,
  output logic                         inst_mem_wr_en_out,
  output logic                         boot_mode_out,
  output logic                         boot_done_out,
  output logic [COUNT_WIDTH-1:0]       boot_count_out
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_LOAD    = 2'b01,
    ST_RELEASE = 2'b10,
    ST_RUN     = 2'b11
  } state_t;

  state_t                   state_r;
  state_t                   next_state_s;
  logic [COUNT_WIDTH-1:0]   count_r;
  logic [COUNT_WIDTH-1:0]   length_r;
  logic                     boot_mode_r;
  logic                     boot_done_r;
  logic                     ready_s;
  logic                     accept_s;
  logic                     load_entry_s;
  logic                     last_word_s;
  logic [PC_DATA_WIDTH-1:0] wr_addr_s;

  assign ready_s     = (state_r == ST_LOAD);
  assign accept_s    = boot_valid_in & ready_s;
  assign last_word_s = ((count_r + COUNT_WIDTH'(1'b1)) == length_r);
  // Address wraps silently modulo the PC width.
  assign wr_addr_s   = BOOT_BASE_ADDRESS + PC_DATA_WIDTH'({count_r, 2'b00});

  // Next-state decode; a start request is only honoured from HOLD or RUN.
  always_comb begin
    next_state_s = state_r;
    load_entry_s = 1'b0;
    case (state_r)
      ST_HOLD, ST_RUN: begin
        if (boot_start_in) begin
          if (boot_length_in != {COUNT_WIDTH{1'b0}}) begin
            next_state_s = ST_LOAD;
            load_entry_s = 1'b1;
          end else begin
            next_state_s = ST_RELEASE;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (accept_s && last_word_s) begin
          next_state_s = ST_RELEASE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_RELEASE: next_state_s = ST_RUN;
      default:    next_state_s = ST_HOLD;
    endcase
  end

  // State, word counter and registered boot mode/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_HOLD;
      count_r     <= {COUNT_WIDTH{1'b0}};
      length_r    <= {COUNT_WIDTH{1'b0}};
      boot_mode_r <= 1'b1;
      boot_done_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      boot_mode_r <= (next_state_s != ST_RUN);
      boot_done_r <= (next_state_s == ST_RUN);
      if (load_entry_s) begin
        count_r  <= {COUNT_WIDTH{1'b0}};
        length_r <= boot_length_in;
      end else if (accept_s) begin
        count_r  <= count_r + COUNT_WIDTH'(1'b1);
        length_r <= length_r;
      end else begin
        count_r  <= count_r;
        length_r <= length_r;
      end
    end
  end

  assign boot_ready_out     = ready_s;
  assign inst_mem_wr_en_out = accept_s;
  assign inst_mem_data_out  = boot_data_in;
  assign inst_mem_addr_out  = ready_s ? wr_addr_s : fetch_addr_in;
  assign boot_mode_out      = boot_mode_r;
  assign boot_done_out      = boot_done_r;
  assign boot_count_out     = count_r;

endmodule

// File: tb/tb_boot_fetch_ctrl.sv
// Self-checking bench for boot_fetch_ctrl: two instances (base 0 and a wrapping base)
// share stimulus and are compared each cycle against a phase-level reference model.
module tb_boot_fetch_ctrl;

  localparam int          PW     = 20;
  localparam int          IW     = 32;
  localparam int          CW     = 16;
  localparam logic [19:0] BASE_A = 20'h00000;
  localparam logic [19:0] BASE_B = 20'hFFFF8;
  localparam int P_HOLD = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3;

  logic          clk = 1'b0;
  logic          rst, start, valid;
  logic [CW-1:0] len;
  logic [IW-1:0] data;
  logic [PW-1:0] fetch;

  logic          rdy_a, we_a, mode_a, done_a, rdy_b, we_b, mode_b, done_b;
  logic [PW-1:0] addr_a, addr_b;
  logic [IW-1:0] wd_a, wd_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int vectors = 0;
  int checks = 0;
  int miscompares = 0;

  // Reference model: phase, words written, latched length.
  int ph;
  int mc;
  int ml;

  always #5 clk = ~clk;

  boot_fetch_ctrl #(.PC_DATA_WIDTH(PW), .INSTRUCTION_WIDTH(IW),
                    .BOOT_BASE_ADDRESS(BASE_A), .COUNT_WIDTH(CW)) dut_a (
    .clk(clk), .rst(rst), .boot_start_in(start), .boot_length_in(len),
    .boot_data_in(data), .boot_valid_in(valid), .boot_ready_out(rdy_a),
    .fetch_addr_in(fetch), .inst_mem_addr_out(addr_a), .inst_mem_data_out(wd_a),
    .inst_mem_wr_en_out(we_a), .boot_mode_out(mode_a), .boot_done_out(done_a),
    .boot_count_out(cnt_a));

  boot_fetch_ctrl #(.PC_DATA_WIDTH(PW), .INSTRUCTION_WIDTH(IW),
                    .BOOT_BASE_ADDRESS(BASE_B), .COUNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst(rst), .boot_start_in(start), .boot_length_in(len),
    .boot_data_in(data), .boot_valid_in(valid), .boot_ready_out(rdy_b),
    .fetch_addr_in(fetch), .inst_mem_addr_out(addr_b), .inst_mem_data_out(wd_b),
    .inst_mem_wr_en_out(we_b), .boot_mode_out(mode_b), .boot_done_out(done_b),
    .boot_count_out(cnt_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic r, input logic s, input int l, input logic v);
    logic          loading;
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    rst = r; start = s; len = CW'(l); valid = v;
    data = $urandom; fetch = PW'($urandom);
    vectors++;
    #1;
    loading = (ph == P_LOAD);
    ea = PW'((longint'(BASE_A) + longint'(mc) * 4) % (longint'(1) << PW));
    eb = PW'((longint'(BASE_B) + longint'(mc) * 4) % (longint'(1) << PW));
    check("ready_a", rdy_a, loading);
    check("ready_b", rdy_b, loading);
    check("wr_en_a", we_a, loading & v);
    check("wr_en_b", we_b, loading & v);
    check("addr_a", addr_a, loading ? ea : fetch);
    check("addr_b", addr_b, loading ? eb : fetch);
    check("wdata_a", wd_a, data);
    check("wdata_b", wd_b, data);
    check("mode_a", mode_a, ph != P_RUN);
    check("mode_b", mode_b, ph != P_RUN);
    check("done_a", done_a, ph == P_RUN);
    check("done_b", done_b, ph == P_RUN);
    check("count_a", cnt_a, mc);
    check("count_b", cnt_b, mc);
    @(posedge clk);
    if (r) begin
      ph = P_HOLD;
      mc = 0;
    end else if (ph == P_LOAD) begin
      if (v) begin
        mc++;
        if (mc == ml) ph = P_REL;
      end
    end else if (ph == P_REL) begin
      ph = P_RUN;
    end else if (s) begin
      if (l == 0) ph = P_REL;
      else begin
        ph = P_LOAD;
        mc = 0;
        ml = l;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; valid = 1'b0; data = '0; fetch = '0;
    @(posedge clk);
    @(negedge clk);
    ph = P_HOLD; mc = 0; ml = 0;

    // Reset state, with start asserted alongside reset to show reset wins.
    cycle(1'b1, 1'b1, 4, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b0);
    check("reset_mode", mode_a, 1'b1);
    check("reset_count", cnt_a, 16'd0);

    // Basic boot: 4 words back to back.
    cycle(1'b0, 1'b1, 4, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    check("basic_count", cnt_a, 16'd4);
    check("basic_done", done_a, 1'b1);

    // Gapped loader: valid 1,0,0,1,0,1, with a reload from RUN.
    cycle(1'b0, 1'b1, 3, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    check("gap_count", cnt_a, 16'd3);

    // Zero length from HOLD.
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 1'b1);
    check("zero_done", done_a, 1'b1);

    // Reset mid-load after 2 of 5 words, then a clean 2-word load.
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 5, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    check("rst_mid_count", cnt_a, 16'd0);
    cycle(1'b0, 1'b1, 2, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 1'b0);

    // Reboot from RUN with start pulses during LOAD.
    cycle(1'b0, 1'b1, 2, 1'b0);
    cycle(1'b0, 1'b1, 7, 1'b0);
    cycle(1'b0, 1'b1, 3, 1'b1);
    cycle(1'b0, 1'b1, 1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    check("reboot_count", cnt_a, 16'd2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
